// File: rtl/axi4lite_pkg.sv
// axi4lite_pkg
//   Shared definitions for the AXI4-Lite master: default bus widths,
//   response codes and the master FSM state type.
package axi4lite_pkg;

    localparam int AXI_ADDR_WIDTH_DEF = 32;
    localparam int AXI_DATA_WIDTH_DEF = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,  // AW and W in flight
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_RSP     = 3'd5
    } mst_state_e;

endpackage

// File: rtl/axi4lite_master.sv
// axi4lite_master
//   Command-driven AXI4-Lite master, one transaction outstanding.
//   cmd_*  : valid/ready request port (write flag, byte address, write data)
//   rsp_*  : valid/ready response port (write echo, read data, raw RESP code)
//   AW/W/B/AR/R : AXI4-Lite master-side channels
//   A_CLK rising edge; A_RST synchronous, active-high.
//   Optional macro AXI4LITE_MASTER_WSTRB_EN adds cmd_wstrb / W_STRB.
//   All AXI VALID/READY and rsp_valid outputs are registered and derived
//   from the next state, so no VALID ever depends combinationally on a READY.
module axi4lite_master
    import axi4lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = AXI_ADDR_WIDTH_DEF,
    parameter int AXI_DATA_WIDTH = AXI_DATA_WIDTH_DEF
) (
    input  logic                      A_CLK,
    input  logic                      A_RST,
    // command port
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0] cmd_wdata,
`ifdef AXI4LITE_MASTER_WSTRB_EN
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
`endif
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [AXI_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                rsp_resp,
    // AXI4-Lite write channels
    output logic                      AW_VALID,
    input  logic                      AW_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AW_ADDR,
    output logic                      W_VALID,
    input  logic                      W_READY,
    output logic [AXI_DATA_WIDTH-1:0] W_DATA,
`ifdef AXI4LITE_MASTER_WSTRB_EN
    output logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
`endif
    input  logic                      B_VALID,
    output logic                      B_READY,
    input  logic [1:0]                B_RESP,
    // AXI4-Lite read channels
    output logic                      AR_VALID,
    input  logic                      AR_READY,
    output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
    input  logic                      R_VALID,
    output logic                      R_READY,
    input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
    input  logic [1:0]                R_RESP
);

    mst_state_e                state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                      write_q, write_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                resp_q, resp_d;
    logic                      aw_valid_q, aw_valid_d;
    logic                      w_valid_q, w_valid_d;
    logic                      b_ready_q, b_ready_d;
    logic                      ar_valid_q, ar_valid_d;
    logic                      r_ready_q, r_ready_d;
    logic                      rsp_valid_q, rsp_valid_d;
`ifdef AXI4LITE_MASTER_WSTRB_EN
    logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
`ifdef AXI4LITE_MASTER_WSTRB_EN
        wstrb_d   = wstrb_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    write_d   = cmd_write;
`ifdef AXI4LITE_MASTER_WSTRB_EN
                    wstrb_d   = cmd_wstrb;
`endif
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_write ? ST_WR : ST_RD_ADDR;
                end
            end
            ST_WR: begin
                // AW and W complete independently, possibly in the same cycle
                aw_done_d = aw_done_q | (aw_valid_q & AW_READY);
                w_done_d  = w_done_q  | (w_valid_q  & W_READY);
                if (aw_done_d && w_done_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (B_VALID) begin
                    rdata_d = '0;
                    resp_d  = B_RESP;
                    state_d = ST_RSP;
                end
            end
            ST_RD_ADDR: begin
                if (AR_READY) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (R_VALID) begin
                    rdata_d = R_DATA;
                    resp_d  = R_RESP;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Channel strobes follow the state being entered, keeping them registered
        aw_valid_d  = (state_d == ST_WR) && !aw_done_d;
        w_valid_d   = (state_d == ST_WR) && !w_done_d;
        b_ready_d   = (state_d == ST_WR_RESP);
        ar_valid_d  = (state_d == ST_RD_ADDR);
        r_ready_d   = (state_d == ST_RD_DATA);
        rsp_valid_d = (state_d == ST_RSP);
    end

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
`ifdef AXI4LITE_MASTER_WSTRB_EN
            wstrb_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef AXI4LITE_MASTER_WSTRB_EN
            wstrb_q     <= wstrb_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = write_q;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign AW_VALID  = aw_valid_q;
    assign AW_ADDR   = addr_q;
    assign W_VALID   = w_valid_q;
    assign W_DATA    = wdata_q;
    assign B_READY   = b_ready_q;
    assign AR_VALID  = ar_valid_q;
    assign AR_ADDR   = addr_q;
    assign R_READY   = r_ready_q;
`ifdef AXI4LITE_MASTER_WSTRB_EN
    assign W_STRB    = (state_q == ST_WR) ? wstrb_q : '0;
`endif

endmodule

// File: doc/axi4lite_master.md
Name: axi4lite_master

Overview:
- Command-driven AXI4-Lite master; sits directly upstream of the AXI4-Lite slave/register bank and drives the master side of axi4lite_if.
- Converts single-beat read/write commands from a simple valid/ready request port into AXI4-Lite channel handshakes.
- Returns read data and response code on a valid/ready response port.
- One transaction outstanding at a time.

Parameters:
AXI_ADDR_WIDTH, 32, width of cmd_addr, AW_ADDR, AR_ADDR
AXI_DATA_WIDTH, 32, width of cmd_wdata, W_DATA, R_DATA, rsp_rdata

Ports:
A_CLK  in  1  clock, all logic on rising edge
A_RST  in  1  synchronous reset, active-high
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&&ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AXI_ADDR_WIDTH  byte address
cmd_wdata  in  AXI_DATA_WIDTH  write data (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&&ready
rsp_write  out  1  echo of cmd_write for this response
rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  B_RESP or R_RESP captured unmodified
AW_VALID/AW_READY/AW_ADDR, W_VALID/W_READY/W_DATA, B_VALID/B_READY/B_RESP, AR_VALID/AR_READY/AR_ADDR, R_VALID/R_READY/R_DATA/R_RESP: AXI4-Lite master side, standard directions and widths

Behaviour:
- Reset: synchronous on A_CLK when A_RST=1; state=IDLE; every output 0 except cmd_ready=1 (combinational from IDLE); address/data registers cleared.
- FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: cmd_ready=1. On cmd_valid: register addr, wdata, write flag. Go to WR if write, RD_ADDR if read. No AXI activity in IDLE.
- WR:
  - AW_VALID and W_VALID both assert the cycle after acceptance.
  - Each drops independently on the cycle after its own handshake; AW_ADDR/W_DATA are held stable while valid.
  - Handshake-done flags are registered and cleared on entry to WR.
  - Simultaneous AW/W handshakes in one cycle are legal. Go to WR_RESP when both flags are set, or on the cycle both complete.
- WR_RESP: B_READY=1. On B_VALID capture B_RESP, rsp_rdata=0, go to RSP.
- RD_ADDR: AR_VALID=1, AR_ADDR held. On AR_READY go to RD_DATA.
- RD_DATA: R_READY=1. On R_VALID capture R_DATA and R_RESP, go to RSP.
- RSP: rsp_valid=1, outputs stable until rsp_ready; then go to IDLE. rsp_ready already high → one-cycle RSP.
- Latency:
  - Minimum write (slave ready immediately, B same cycle): accept edge N, AW/W valid N+1, B_READY N+2, rsp_valid N+3.
  - Minimum read: accept N, AR_VALID N+1, R_READY N+2, rsp_valid N+3.
- No dependency of any VALID on any READY; VALID never deasserts before its handshake.
- cmd_valid in non-IDLE states is ignored (cmd_ready=0); no queuing.
- rsp_resp is passed through unmodified; the master does not interpret it. Slave EXOKAY (1) is reported as 1.
- Reset mid-transaction: all VALID/READY outputs 0 the following cycle, pending command discarded, no response emitted.
- Back-to-back: the next command may be accepted the cycle after rsp handshake (IDLE cycle).

Optional Feature:
- Macro: AXI4LITE_MASTER_WSTRB_EN.
- Defined:
  - Adds input cmd_wstrb [AXI_DATA_WIDTH/8] and output W_STRB [AXI_DATA_WIDTH/8].
  - cmd_wstrb is registered at acceptance and held with W_DATA.
  - W_STRB is 0 outside WR.
- Undefined: both ports absent. The downstream slave treats all writes as full-word.

Decomposition:
- Package axi4lite_pkg:
  - AXI_ADDR_WIDTH/AXI_DATA_WIDTH defaults.
  - Response codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Master state enum typedef.
- No sub-module. Single FSM, output registers driven directly from state and capture registers.
- Bench top pairs axi4lite_master with the existing axi4lite_slave through axi4lite_if.

Test Plan:
- Reset: hold A_RST=1 for 3 cycles with cmd_valid=1 → all AXI VALID/READY 0, rsp_valid 0, cmd_ready 1, no AW/AR issued.
- Write: cmd write addr 0x4, data 0xDEADBEEF, slave AW_READY after 2 cycles, W_READY immediate → W_VALID drops 1 cycle before AW_VALID, B_READY asserted, rsp_valid with rsp_write=1, rsp_resp=B_RESP, rsp_rdata=0.
- Read-back: cmd read 0x4 against axi4lite_slave → AR_ADDR=0x4, rsp_rdata=0xDEADBEEF, rsp_resp=2'b01 (slave EXOKAY passed through).
- Response stall: hold rsp_ready=0 for 5 cycles → rsp_valid/rdata/resp stable, cmd_ready=0, new cmd_valid ignored; release → IDLE next cycle.
- Reset mid-write: assert A_RST while AW_VALID=1 and B pending → AW_VALID/W_VALID/B_READY 0 next cycle, no rsp_valid, next write completes normally.
- With AXI4LITE_MASTER_WSTRB_EN: cmd_wstrb=4'b0011 → W_STRB=4'b0011 during WR, 0 otherwise.
